pattern_response_misr: RTL and testbench



---
 rtl/pattern_response_misr_if.sv | 26 ++
 rtl/pattern_response_misr.sv | 94 +++++++++
 tb/tb_pattern_response_misr.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_response_misr_if.sv
// Handshake/result bundle between a merged pattern's response side and the signature checker.
interface pattern_response_misr_if #(
    parameter int RESP_W = 10,
    parameter int SIG_W  = 16
);
    logic              start;
    logic              abort;
    logic              resp_valid;
    logic [RESP_W-1:0] resp_in;
    logic [SIG_W-1:0]  golden_sig;
    logic              busy;
    logic              done;
    logic              match;
    logic [SIG_W-1:0]  signature;
    logic [15:0]       vec_count;

    modport master (
        output start, abort, resp_valid, resp_in, golden_sig,
        input  busy, done, match, signature, vec_count
    );

    modport slave (
        input  start, abort, resp_valid, resp_in, golden_sig,
        output busy, done, match, signature, vec_count
    );
endinterface

// File: rtl/pattern_response_misr.sv
// Compacts captured response vectors into a MISR after a warm-up window and
// compares the final signature against a golden value.
module pattern_response_misr #(
    parameter int               RESP_W      = 10,
    parameter int               SIG_W       = 16,
    parameter logic [SIG_W-1:0] POLY        = 16'h1021,
    parameter logic [SIG_W-1:0] SEED        = 16'h0000,
    parameter int               WARMUP      = 3,
    parameter int               NUM_VECTORS = 256
) (
    input logic                    blif_clk_net,
    input logic                    blif_reset_net,
    pattern_response_misr_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WARM, S_COMPACT, S_DONE} state_t;

    // WARM_LAST wraps when WARMUP=0, but S_WARM is never entered in that case.
    localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);
    localparam logic [15:0] VEC_LAST  = 16'(NUM_VECTORS - 1);
    localparam state_t      RUN_ENTRY = (WARMUP == 0) ? S_COMPACT : S_WARM;

    state_t           state;
    logic [SIG_W-1:0] sig_r;
    logic [SIG_W-1:0] sig_next;
    logic [15:0]      cnt_r;
    logic [15:0]      warm_cnt;
    logic             busy_r;
    logic             done_r;
    logic             match_r;

    always_comb begin
        sig_next = {sig_r[SIG_W-2:0], 1'b0}
                 ^ (sig_r[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(bus.resp_in);
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state    <= S_IDLE;
            sig_r    <= SEED;
            cnt_r    <= '0;
            warm_cnt <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            match_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // Abort leaves signature and count untouched so a cancelled run can be inspected.
            if (bus.abort) begin
                state   <= S_IDLE;
                busy_r  <= 1'b0;
                match_r <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (bus.start) begin
                            sig_r    <= SEED;
                            cnt_r    <= '0;
                            warm_cnt <= '0;
                            match_r  <= 1'b0;
                            busy_r   <= 1'b1;
                            state    <= RUN_ENTRY;
                        end
                    end
                    S_WARM: begin
                        if (bus.resp_valid) begin
                            warm_cnt <= warm_cnt + 16'd1;
                            if (warm_cnt == WARM_LAST) state <= S_COMPACT;
                        end
                    end
                    S_COMPACT: begin
                        if (bus.resp_valid) begin
                            sig_r <= sig_next;
                            if (cnt_r != 16'hFFFF) cnt_r <= cnt_r + 16'd1;
                            if (cnt_r == VEC_LAST) begin
                                state   <= S_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                match_r <= (sig_next == bus.golden_sig);
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.match     = match_r;
    assign bus.signature = sig_r;
    assign bus.vec_count = cnt_r;
endmodule

// File: tb/tb_pattern_response_misr.sv
// Scoreboard bench: three differently parameterised checkers, directed scenarios plus
// randomized runs checked against a polynomial-arithmetic signature model.
module tb_pattern_response_misr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       start_v = '0, abort_v = '0, valid_v = '0;
    logic [2:0][9:0]  resp_v  = '0;
    logic [2:0][15:0] gold_v  = '0;
    wire  [2:0]       busy_v, done_v, match_v;
    wire  [2:0][15:0] sig_v, vcnt_v;

    pattern_response_misr_if #(.RESP_W(10), .SIG_W(16)) bus_a ();
    pattern_response_misr_if #(.RESP_W(10), .SIG_W(16)) bus_b ();
    pattern_response_misr_if #(.RESP_W(10), .SIG_W(16)) bus_c ();

    assign bus_a.start = start_v[0];  assign bus_b.start = start_v[1];  assign bus_c.start = start_v[2];
    assign bus_a.abort = abort_v[0];  assign bus_b.abort = abort_v[1];  assign bus_c.abort = abort_v[2];
    assign bus_a.resp_valid = valid_v[0]; assign bus_b.resp_valid = valid_v[1]; assign bus_c.resp_valid = valid_v[2];
    assign bus_a.resp_in = resp_v[0]; assign bus_b.resp_in = resp_v[1]; assign bus_c.resp_in = resp_v[2];
    assign bus_a.golden_sig = gold_v[0]; assign bus_b.golden_sig = gold_v[1]; assign bus_c.golden_sig = gold_v[2];
    assign busy_v  = {bus_c.busy,  bus_b.busy,  bus_a.busy};
    assign done_v  = {bus_c.done,  bus_b.done,  bus_a.done};
    assign match_v = {bus_c.match, bus_b.match, bus_a.match};
    assign sig_v   = {bus_c.signature, bus_b.signature, bus_a.signature};
    assign vcnt_v  = {bus_c.vec_count, bus_b.vec_count, bus_a.vec_count};

    pattern_response_misr #(.WARMUP(0), .NUM_VECTORS(2), .SEED(16'h0000)) u_a (
        .blif_clk_net(clk), .blif_reset_net(rst), .bus(bus_a));
    pattern_response_misr #(.WARMUP(0), .NUM_VECTORS(1), .SEED(16'h8000)) u_b (
        .blif_clk_net(clk), .blif_reset_net(rst), .bus(bus_b));
    pattern_response_misr #(.WARMUP(3), .NUM_VECTORS(4), .SEED(16'h0000)) u_c (
        .blif_clk_net(clk), .blif_reset_net(rst), .bus(bus_c));

    function automatic int wu(input int k);   return (k == 2) ? 3 : 0; endfunction
    function automatic int nv(input int k);   return (k == 0) ? 2 : (k == 1) ? 1 : 4; endfunction
    function automatic int seed(input int k); return (k == 1) ? 32'h8000 : 0; endfunction

    // Signature as repeated multiply-by-x modulo x^16 + POLY, plus the response word.
    function automatic logic [15:0] model_sig(input int k, input logic [9:0] beats[$]);
        int s = seed(k);
        for (int i = wu(k); i < wu(k) + nv(k); i++) begin
            s = s * 2;
            if (s >= 65536) s = (s - 65536) ^ 32'h1021;
            s = s ^ int'(beats[i]);
        end
        return 16'(s);
    endfunction

    typedef struct {
        int          k;
        logic [15:0] sig;
        logic        m;
        logic [15:0] cnt;
    } exp_t;
    exp_t sq[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst=%0d got=%h want=%h", nm, k, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (done_v[k]) begin
                    if (sq.size() == 0 || sq[0].k != k) begin
                        n_chk++;
                        $display("FAIL unexpected_done inst=%0d got=%h want=no_done", k, sig_v[k]);
                    end else begin
                        exp_t e;
                        e = sq.pop_front();
                        chk("final_sig",   k, sig_v[k],   e.sig);
                        chk("final_match", k, match_v[k], e.m);
                        chk("final_count", k, vcnt_v[k],  e.cnt);
                    end
                end
            end
        end
    end

    task automatic rand_run(input int k, input bit fixed, input int gapmax);
        logic [9:0]  beats[$];
        logic [15:0] es, g;
        int          nb;
        nb = wu(k) + nv(k);
        for (int i = 0; i < nb; i++) beats.push_back(fixed ? 10'h001 : 10'($urandom));
        es = model_sig(k, beats);
        g  = ($urandom_range(0, 1) == 1) ? es : es ^ 16'($urandom_range(1, 65535));
        gold_v[k] = g;
        sq.push_back('{k, es, (g == es), 16'(nv(k))});
        // The beat sampled alongside start must not be compacted.
        start_v[k] = 1'b1; valid_v[k] = 1'($urandom_range(0, 1)); resp_v[k] = 10'($urandom);
        cyc();
        start_v[k] = 1'b0; valid_v[k] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, gapmax)) cyc();
            valid_v[k] = 1'b1; resp_v[k] = beats[i];
            start_v[k] = (i < nb - 1) && ($urandom_range(0, 3) == 0);
            cyc();
            valid_v[k] = 1'b0; start_v[k] = 1'b0;
        end
        chk("run_count", k, vcnt_v[k], nv(k));
        chk("run_busy",  k, busy_v[k], 0);
        for (int t = 0; t < 8 && sq.size() != 0; t++) cyc();
        chk("sb_drain", k, sq.size(), 0);
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    initial begin
        repeat (3) cyc();
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", k, busy_v[k], 0);
            chk("rst_sig",  k, sig_v[k], seed(k));
            chk("rst_cnt",  k, vcnt_v[k], 0);
        end
        rst = 1'b0;
        cyc();

        // Two unit beats, no warm-up.
        gold_v[0] = 16'h0003;
        sq.push_back('{0, 16'h0003, 1'b1, 16'd2});
        start_v[0] = 1'b1; cyc(); start_v[0] = 1'b0;
        chk("a_busy", 0, busy_v[0], 1);
        valid_v[0] = 1'b1; resp_v[0] = 10'h001; cyc();
        chk("a_sig1", 0, sig_v[0], 16'h0001);
        chk("a_cnt1", 0, vcnt_v[0], 1);
        cyc();
        chk("a_sig2", 0, sig_v[0], 16'h0003);
        chk("a_done", 0, done_v[0], 1);
        valid_v[0] = 1'b0; cyc();
        chk("a_done_pulse", 0, done_v[0], 0);
        chk("a_match_hold", 0, match_v[0], 1);
        abort_v[0] = 1'b1; cyc(); abort_v[0] = 1'b0;
        chk("a_abort_match", 0, match_v[0], 0);
        chk("a_abort_sig",   0, sig_v[0], 16'h0003);

        // Feedback from SEED MSB, mismatching golden.
        gold_v[1] = 16'h1020;
        sq.push_back('{1, 16'h1021, 1'b0, 16'd1});
        start_v[1] = 1'b1; cyc(); start_v[1] = 1'b0;
        valid_v[1] = 1'b1; resp_v[1] = 10'h000; cyc(); valid_v[1] = 1'b0;
        chk("b_sig",   1, sig_v[1], 16'h1021);
        chk("b_done",  1, done_v[1], 1);
        chk("b_match", 1, match_v[1], 0);
        cyc();

        // Warm-up discard, then abort mid-compaction with start and a beat in the same cycle.
        gold_v[2] = 16'h0000;
        start_v[2] = 1'b1; cyc(); start_v[2] = 1'b0;
        chk("c_busy", 2, busy_v[2], 1);
        for (int i = 0; i < 3; i++) begin
            valid_v[2] = 1'b1; resp_v[2] = 10'h3FF; cyc();
            chk("c_warm_sig", 2, sig_v[2], 16'h0000);
            chk("c_warm_cnt", 2, vcnt_v[2], 0);
        end
        resp_v[2] = 10'h002; cyc();
        chk("c_sig1", 2, sig_v[2], 16'h0002);
        resp_v[2] = 10'h005; cyc();
        chk("c_sig2", 2, sig_v[2], 16'h0001);
        chk("c_cnt2", 2, vcnt_v[2], 2);
        abort_v[2] = 1'b1; start_v[2] = 1'b1; resp_v[2] = 10'h3FF; cyc();
        abort_v[2] = 1'b0; start_v[2] = 1'b0; valid_v[2] = 1'b0;
        chk("c_abort_busy", 2, busy_v[2], 0);
        chk("c_abort_done", 2, done_v[2], 0);
        chk("c_abort_sig",  2, sig_v[2], 16'h0001);
        chk("c_abort_cnt",  2, vcnt_v[2], 2);
        repeat (3) cyc();
        chk("c_abort_idle", 2, busy_v[2], 0);
        start_v[2] = 1'b1; cyc(); start_v[2] = 1'b0;
        chk("c_restart_sig", 2, sig_v[2], 16'h0000);
        chk("c_restart_cnt", 2, vcnt_v[2], 0);
        chk("c_restart_busy", 2, busy_v[2], 1);

        // Reset mid-run, with start held during reset.
        for (int i = 0; i < 4; i++) begin
            valid_v[2] = 1'b1; resp_v[2] = (i == 3) ? 10'h155 : 10'h3FF; cyc();
        end
        valid_v[2] = 1'b0;
        chk("c_pre_rst_sig", 2, sig_v[2], 16'h0155);
        rst = 1'b1; start_v[2] = 1'b1; cyc();
        chk("c_rst_busy", 2, busy_v[2], 0);
        chk("c_rst_sig",  2, sig_v[2], 16'h0000);
        chk("c_rst_cnt",  2, vcnt_v[2], 0);
        rst = 1'b0; start_v[2] = 1'b0; cyc();
        chk("c_post_rst_idle", 2, busy_v[2], 0);

        for (int r = 0; r < 4; r++) rand_run(0, 1'b1, 4);
        for (int r = 0; r < 12; r++) rand_run(r % 3, 1'b0, 3);

        repeat (4) cyc();
        chk("sb_empty", 0, sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
